// File: rtl/bcd_bin_seq.sv
// Sequential BCD-to-binary converter: Horner iteration, one digit per clock, MSD first.
// The multiply-by-10 is built from shifts and adds; a digit above 9 forces the result to zero and raises err.
module bcd_bin_seq #(
    parameter int N_DIG = 4,
    parameter int BIN_W = 14,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*N_DIG-1:0]   num_BCD,
    output logic                 busy,
    output logic                 done,
    output logic [BIN_W-1:0]     num_bin,
    output logic                 err
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [4*N_DIG-1:0]   operand_reg, operand_next;
    logic [BIN_W-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 err_sticky_reg, err_sticky_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [BIN_W-1:0]     num_bin_reg, num_bin_next;
    logic                 err_reg, err_next;

    // Unpacked view of the latched operand, one nibble per digit.
    logic [3:0] digit [N_DIG];

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
            assign digit[gi] = operand_reg[4*gi +: 4];
        end
    endgenerate

    // Digit select as an explicit compare-mux so the counter width need not
    // match the array index width.
    logic [3:0] cur_digit;
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < N_DIG; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                cur_digit = digit[i];
            end
        end
    end

    logic [BIN_W-1:0] acc_x10;
    logic [BIN_W-1:0] acc_step;
    logic             digit_bad;
    logic             err_step;

    assign acc_x10   = (acc_reg << 3) + (acc_reg << 1);
    assign acc_step  = acc_x10 + BIN_W'(cur_digit);
    assign digit_bad = (cur_digit > 4'd9);
    assign err_step  = err_sticky_reg | digit_bad;

    always_comb begin
        state_next      = state_reg;
        operand_next    = operand_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        err_sticky_next = err_sticky_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        num_bin_next    = num_bin_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    operand_next    = num_BCD;
                    acc_next        = '0;
                    cnt_next        = CNT_W'(N_DIG - 1);
                    err_sticky_next = 1'b0;
                    busy_next       = 1'b1;
                    state_next      = CONV;
                end
            end
            CONV: begin
                acc_next        = acc_step;
                err_sticky_next = err_step;
                cnt_next        = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    num_bin_next = err_step ? '0 : acc_step;
                    err_next     = err_step;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            operand_reg    <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            err_sticky_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            num_bin_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            operand_reg    <= operand_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            err_sticky_reg <= err_sticky_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            num_bin_reg    <= num_bin_next;
            err_reg        <= err_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign num_bin = num_bin_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Directed bench for bcd_bin_seq: a 4-digit instance and a 6-digit instance share clock and reset.
module tb_bcd_bin_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a;
    logic [15:0] bcd_a;
    logic        busy_a, done_a, err_a;
    logic [13:0] bin_a;

    logic        start_b;
    logic [23:0] bcd_b;
    logic        busy_b, done_b, err_b;
    logic [19:0] bin_b;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bcd_bin_seq #(.N_DIG(4), .BIN_W(14), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_BCD(bcd_a),
        .busy(busy_a), .done(done_a), .num_bin(bin_a), .err(err_a)
    );

    bcd_bin_seq #(.N_DIG(6), .BIN_W(20), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_BCD(bcd_b),
        .busy(busy_b), .done(done_b), .num_bin(bin_b), .err(err_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch_a(input logic [15:0] v);
        bcd_a   = v;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cycles);
        cycles = 0;
        while (!done_a && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic count_done_a(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done_a) pulses++;
        end
    endtask

    int lat, pulses;

    initial begin
        rst = 1'b1; start_a = 1'b0; bcd_a = '0; start_b = 1'b0; bcd_b = '0;
        tick(); tick();
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_bin",  bin_a,  0);
        check_val("rst_err",  err_a,  0);
        rst = 1'b0;
        tick();

        // 1234: busy four cycles, then one-cycle done.
        launch_a(16'h1234);
        check_val("t1_busy", busy_a, 1);
        wait_done_a(lat);
        check_val("t1_lat", lat, 4);
        check_val("t1_bin", bin_a, 1234);
        check_val("t1_err", err_a, 0);
        check_val("t1_busy_end", busy_a, 0);
        $display("xfer 1234 -> %0d err=%0d lat=%0d", bin_a, err_a, lat);
        tick();
        check_val("t1_done_width", done_a, 0);
        check_val("t1_bin_hold", bin_a, 1234);

        // 9999 then 0000 started in the done cycle.
        launch_a(16'h9999);
        wait_done_a(lat);
        check_val("t2a_lat", lat, 4);
        check_val("t2a_bin", bin_a, 9999);
        $display("xfer 9999 -> %0d err=%0d lat=%0d", bin_a, err_a, lat);
        launch_a(16'h0000);
        check_val("t2b_done_width", done_a, 0);
        check_val("t2b_busy", busy_a, 1);
        wait_done_a(lat);
        check_val("t2b_gap", lat + 1, 5);
        check_val("t2b_bin", bin_a, 0);
        check_val("t2b_err", err_a, 0);
        $display("xfer 0000 -> %0d err=%0d lat=%0d", bin_a, err_a, lat);
        tick();

        // Invalid digit, then a clean conversion clears err.
        launch_a(16'h12A4);
        wait_done_a(lat);
        check_val("t3a_lat", lat, 4);
        check_val("t3a_bin", bin_a, 0);
        check_val("t3a_err", err_a, 1);
        $display("xfer 12A4 -> %0d err=%0d lat=%0d", bin_a, err_a, lat);
        tick();
        check_val("t3a_err_hold", err_a, 1);
        launch_a(16'h0042);
        wait_done_a(lat);
        check_val("t3b_bin", bin_a, 42);
        check_val("t3b_err", err_a, 0);
        $display("xfer 0042 -> %0d err=%0d lat=%0d", bin_a, err_a, lat);
        tick();

        // Start pulses and operand changes while busy are ignored.
        launch_a(16'h0500);
        start_a = 1'b1;
        bcd_a   = 16'h7777;
        tick(); tick(); tick();
        start_a = 1'b0;
        wait_done_a(lat);
        check_val("t4_lat", lat + 3, 4);
        check_val("t4_bin", bin_a, 500);
        $display("xfer 0500 -> %0d err=%0d lat=%0d", bin_a, err_a, lat + 3);
        count_done_a(8, pulses);
        check_val("t4_single_done", pulses, 0);

        // Reset at the second digit step aborts the conversion.
        launch_a(16'h8888);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_busy", busy_a, 0);
        check_val("t5_done", done_a, 0);
        check_val("t5_bin",  bin_a,  0);
        check_val("t5_err",  err_a,  0);
        count_done_a(8, pulses);
        check_val("t5_no_done", pulses, 0);
        $display("xfer 8888 aborted by reset, done pulses after=%0d", pulses);

        // Reset and start together: start is not accepted.
        bcd_a = 16'h0321; start_a = 1'b1; rst = 1'b1;
        tick();
        start_a = 1'b0; rst = 1'b0;
        check_val("t6_busy", busy_a, 0);
        count_done_a(8, pulses);
        check_val("t6_no_done", pulses, 0);
        $display("xfer 0321 with reset -> done pulses=%0d", pulses);

        // Six-digit instance.
        bcd_b = 24'h999999; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check_val("t7_busy", busy_b, 1);
        lat = 0;
        while (!done_b && lat < 20) begin
            tick();
            lat++;
        end
        check_val("t7_lat", lat, 6);
        check_val("t7_bin", bin_b, 999999);
        check_val("t7_err", err_b, 0);
        $display("xfer 999999 -> %0d err=%0d lat=%0d", bin_b, err_b, lat);
        bcd_b = 24'h123456; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 20) begin
            tick();
            lat++;
        end
        check_val("t8_lat", lat, 6);
        check_val("t8_bin", bin_b, 123456);
        $display("xfer 123456 -> %0d err=%0d lat=%0d", bin_b, err_b, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
